// File: rtl/axi_slave_demux_r_pkg.sv
// Shared definitions for the AXI read/write response demultiplexers: master index type,
// index constants and the grant encoder. Bus widths come from LEN_BITS/ID_BITS/DATA_WIDTH defines.
`ifndef LEN_BITS
`define LEN_BITS 8
`endif
`ifndef ID_BITS
`define ID_BITS 4
`endif
`ifndef DATA_WIDTH
`define DATA_WIDTH 32
`endif

package axi_slave_demux_r_pkg;

    typedef logic [1:0] mst_idx_t;

    localparam mst_idx_t MST_M0 = 2'd0;
    localparam mst_idx_t MST_M1 = 2'd1;
    localparam mst_idx_t MST_M2 = 2'd2;

    function automatic mst_idx_t grant_to_idx(input logic [2:0] grant);
        mst_idx_t idx;
        idx = MST_M0;
        if (grant[2]) begin
            idx = MST_M2;
        end else if (grant[1]) begin
            idx = MST_M1;
        end
        return idx;
    endfunction

    function automatic logic grant_is_onehot(input logic [2:0] grant);
        return (grant == 3'b001) || (grant == 3'b010) || (grant == 3'b100);
    endfunction

endpackage

// File: rtl/axi_ord_fifo.sv
// In-order tracking FIFO with a separate occupancy counter; shared by the R and B demuxes.
module axi_ord_fifo #(
    parameter int WIDTH = 2,
    parameter int DEPTH = 4
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     push,
    input  logic [WIDTH-1:0]         push_data,
    input  logic                     pop,
    output logic [WIDTH-1:0]         head_data,
    output logic                     full,
    output logic                     empty,
    output logic [$clog2(DEPTH):0]   count
);

    localparam int PW = $clog2(DEPTH);
    localparam logic [PW:0] DEPTH_CNT = DEPTH[PW:0];

    logic [WIDTH-1:0] mem [DEPTH];
    logic [PW-1:0]    wr_ptr;
    logic [PW-1:0]    rd_ptr;
    logic             do_push;
    logic             do_pop;

    assign full    = (count == DEPTH_CNT);
    assign empty   = (count == '0);
    assign do_push = push && !full;
    assign do_pop  = pop && !empty;

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (do_pop) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            // Simultaneous push and pop leaves the occupancy unchanged.
            if (do_push && !do_pop) begin
                count <= count + 1'b1;
            end else if (do_pop && !do_push) begin
                count <= count - 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (do_push) begin
            mem[wr_ptr] <= push_data;
        end
    end

    assign head_data = mem[rd_ptr];

endmodule

// File: rtl/axi_slave_demux_r.sv
// Routes slave R beats back to the master that won each AR, in order, until RLAST.
// Optional burst-length checking is enabled by defining AXI_R_LEN_CHECK_EN.
module axi_slave_demux_r
    import axi_slave_demux_r_pkg::*;
#(
    parameter int DEPTH = 4
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   m0_rgrnt,
    input  logic                   m1_rgrnt,
    input  logic                   m2_rgrnt,
    input  logic                   arvalid,
    input  logic [`LEN_BITS-1:0]   arlen,
    input  logic                   arready_i,
    output logic                   arready_o,
    input  logic [`ID_BITS-1:0]    rid,
    input  logic [`DATA_WIDTH-1:0] rdata,
    input  logic [1:0]             rresp,
    input  logic                   rlast,
    input  logic                   rvalid,
    output logic                   rready,
    output logic [`ID_BITS-1:0]    m0_RID,
    output logic [`DATA_WIDTH-1:0] m0_RDATA,
    output logic [1:0]             m0_RRESP,
    output logic                   m0_RLAST,
    output logic                   m0_RVALID,
    input  logic                   m0_RREADY,
    output logic [`ID_BITS-1:0]    m1_RID,
    output logic [`DATA_WIDTH-1:0] m1_RDATA,
    output logic [1:0]             m1_RRESP,
    output logic                   m1_RLAST,
    output logic                   m1_RVALID,
    input  logic                   m1_RREADY,
    output logic [`ID_BITS-1:0]    m2_RID,
    output logic [`DATA_WIDTH-1:0] m2_RDATA,
    output logic [1:0]             m2_RRESP,
    output logic                   m2_RLAST,
    output logic                   m2_RVALID,
    input  logic                   m2_RREADY,
    output logic                   r_err
);

`ifdef AXI_R_LEN_CHECK_EN
    localparam int ENTRY_W = 2 + `LEN_BITS;
`else
    localparam int ENTRY_W = 2;
`endif

    logic [2:0]               grant;
    logic                     push;
    logic                     pop;
    logic                     beat;
    logic                     full;
    logic                     empty;
    logic [$clog2(DEPTH):0]   fifo_count;
    logic [ENTRY_W-1:0]       push_data;
    logic [ENTRY_W-1:0]       head_data;
    mst_idx_t                 head_idx;
    logic                     unused_count;

    assign grant        = {m2_rgrnt, m1_rgrnt, m0_rgrnt};
    assign arready_o    = arready_i && !full;
    assign push         = arvalid && arready_o && grant_is_onehot(grant);
    assign beat         = rvalid && rready;
    assign pop          = beat && rlast;
    assign head_idx     = head_data[1:0];
    assign unused_count = ^fifo_count;

`ifdef AXI_R_LEN_CHECK_EN
    assign push_data = {arlen, grant_to_idx(grant)};
`else
    assign push_data = grant_to_idx(grant);
`endif

    axi_ord_fifo #(
        .WIDTH (ENTRY_W),
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk       (clk),
        .rst       (rst),
        .push      (push),
        .push_data (push_data),
        .pop       (pop),
        .head_data (head_data),
        .full      (full),
        .empty     (empty),
        .count     (fifo_count)
    );

    // Zero-latency steering: only the head master sees the slave, everything else is held at 0.
    always_comb begin
        rready    = 1'b0;
        m0_RID    = '0;
        m0_RDATA  = '0;
        m0_RRESP  = '0;
        m0_RLAST  = 1'b0;
        m0_RVALID = 1'b0;
        m1_RID    = '0;
        m1_RDATA  = '0;
        m1_RRESP  = '0;
        m1_RLAST  = 1'b0;
        m1_RVALID = 1'b0;
        m2_RID    = '0;
        m2_RDATA  = '0;
        m2_RRESP  = '0;
        m2_RLAST  = 1'b0;
        m2_RVALID = 1'b0;
        if (!empty) begin
            case (head_idx)
                MST_M0: begin
                    rready    = m0_RREADY;
                    m0_RVALID = rvalid;
                    m0_RID    = rid;
                    m0_RDATA  = rdata;
                    m0_RRESP  = rresp;
                    m0_RLAST  = rlast;
                end
                MST_M1: begin
                    rready    = m1_RREADY;
                    m1_RVALID = rvalid;
                    m1_RID    = rid;
                    m1_RDATA  = rdata;
                    m1_RRESP  = rresp;
                    m1_RLAST  = rlast;
                end
                MST_M2: begin
                    rready    = m2_RREADY;
                    m2_RVALID = rvalid;
                    m2_RID    = rid;
                    m2_RDATA  = rdata;
                    m2_RRESP  = rresp;
                    m2_RLAST  = rlast;
                end
                default: begin
                end
            endcase
        end
    end

`ifdef AXI_R_LEN_CHECK_EN
    logic [`LEN_BITS-1:0] beat_cnt;
    logic [`LEN_BITS-1:0] head_len;
    logic                 r_err_q;

    assign head_len = head_data[ENTRY_W-1:2];
    assign r_err    = r_err_q;

    // RLAST must coincide exactly with beat arlen; routing still follows RLAST regardless.
    always_ff @(posedge clk) begin
        if (rst) begin
            beat_cnt <= '0;
            r_err_q  <= 1'b0;
        end else if (beat) begin
            if (rlast) begin
                beat_cnt <= '0;
            end else begin
                beat_cnt <= beat_cnt + 1'b1;
            end
            if (rlast != (beat_cnt == head_len)) begin
                r_err_q <= 1'b1;
            end
        end
    end
`else
    logic unused_arlen;
    assign unused_arlen = ^arlen;
    assign r_err        = 1'b0;
`endif

    a_grant_onehot: assert property (@(posedge clk) disable iff (rst)
        (arvalid && arready_o) |-> grant_is_onehot(grant));

endmodule

// File: tb/tb_axi_slave_demux_r.sv
// Scoreboard bench for axi_slave_demux_r: expected R beats are queued at AR acceptance
// and compared at the per-master outputs as the slave returns them.
`timescale 1ns/1ps
module tb_axi_slave_demux_r;
    import axi_slave_demux_r_pkg::*;

    localparam int DEPTH = 4;
    localparam int DW    = `DATA_WIDTH;
    localparam int IW    = `ID_BITS;
    localparam int LW    = `LEN_BITS;
`ifdef AXI_R_LEN_CHECK_EN
    localparam bit LEN_CHECK = 1'b1;
`else
    localparam bit LEN_CHECK = 1'b0;
`endif

    typedef struct {
        int          mst;
        logic [DW-1:0] data;
        logic [IW-1:0] id;
        logic [1:0]    resp;
        logic          last;
    } beat_t;

    beat_t exp_q[$];
    int    vectors     = 0;
    int    miscompares = 0;
    int    outstanding = 0;

    logic             clk = 1'b0;
    logic             rst = 1'b1;
    logic [2:0]       grant = '0;
    logic             arvalid = 1'b0;
    logic [LW-1:0]    arlen = '0;
    logic             arready_i = 1'b1;
    wire              arready_o;
    logic [IW-1:0]    rid = '0;
    logic [DW-1:0]    rdata = '0;
    logic [1:0]       rresp = '0;
    logic             rlast = 1'b0;
    logic             rvalid = 1'b0;
    wire              rready;
    wire [2:0][IW-1:0] m_rid;
    wire [2:0][DW-1:0] m_rdata;
    wire [2:0][1:0]    m_rresp;
    wire [2:0]         m_rlast;
    wire [2:0]         m_rvalid;
    logic [2:0]        m_rready = 3'b111;
    wire               r_err;

    always #5 clk = ~clk;

    axi_slave_demux_r #(.DEPTH(DEPTH)) dut (
        .clk       (clk),
        .rst       (rst),
        .m0_rgrnt  (grant[0]),
        .m1_rgrnt  (grant[1]),
        .m2_rgrnt  (grant[2]),
        .arvalid   (arvalid),
        .arlen     (arlen),
        .arready_i (arready_i),
        .arready_o (arready_o),
        .rid       (rid),
        .rdata     (rdata),
        .rresp     (rresp),
        .rlast     (rlast),
        .rvalid    (rvalid),
        .rready    (rready),
        .m0_RID    (m_rid[0]),
        .m0_RDATA  (m_rdata[0]),
        .m0_RRESP  (m_rresp[0]),
        .m0_RLAST  (m_rlast[0]),
        .m0_RVALID (m_rvalid[0]),
        .m0_RREADY (m_rready[0]),
        .m1_RID    (m_rid[1]),
        .m1_RDATA  (m_rdata[1]),
        .m1_RRESP  (m_rresp[1]),
        .m1_RLAST  (m_rlast[1]),
        .m1_RVALID (m_rvalid[1]),
        .m1_RREADY (m_rready[1]),
        .m2_RID    (m_rid[2]),
        .m2_RDATA  (m_rdata[2]),
        .m2_RRESP  (m_rresp[2]),
        .m2_RLAST  (m_rlast[2]),
        .m2_RVALID (m_rvalid[2]),
        .m2_RREADY (m_rready[2]),
        .r_err     (r_err)
    );

    // Queue the burst's expected beats when the AR handshake is predicted to complete.
    task automatic sb_push_burst(input int mst, input int len, input int base);
        for (int b = 0; b <= len; b++) begin
            beat_t e;
            e.mst  = mst;
            e.data = DW'(base) + DW'(b) + DW'(32'h5A00_0000);
            e.id   = IW'(mst * 4 + b);
            e.resp = 2'(b);
            e.last = (b == len);
            exp_q.push_back(e);
        end
        outstanding++;
    endtask

    task automatic issue_ar(input int mst, input int len, input int base);
        logic exp_rdy;
        grant     = 3'b001 << mst;
        arvalid   = 1'b1;
        arlen     = LW'(len);
        arready_i = 1'b1;
        exp_rdy   = (outstanding < DEPTH);
        @(negedge clk);
        vectors++;
        if (arready_o !== exp_rdy) begin
            miscompares++;
            $display("[TB] FAIL ar_ready m%0d: got %b, want %b", mst, arready_o, exp_rdy);
        end
        @(posedge clk); #1;
        if (exp_rdy) sb_push_burst(mst, len, base);
        arvalid = 1'b0;
        grant   = '0;
    endtask

    // Consume n scoreboard beats with rvalid held high and every master ready.
    task automatic drain_scoreboard(input int n);
        for (int i = 0; i < n; i++) begin
            beat_t e;
            logic  bad;
            e = exp_q.pop_front();
            rvalid   = 1'b1;
            rdata    = e.data;
            rid      = e.id;
            rresp    = e.resp;
            rlast    = e.last;
            m_rready = 3'b111;
            @(negedge clk);
            vectors++;
            bad = (m_rvalid !== (3'b001 << e.mst)) || (rready !== 1'b1) ||
                  (m_rdata[e.mst] !== e.data) || (m_rid[e.mst] !== e.id) ||
                  (m_rresp[e.mst] !== e.resp) || (m_rlast[e.mst] !== e.last);
            for (int j = 0; j < 3; j++) begin
                if (j != e.mst && (m_rdata[j] !== '0 || m_rid[j] !== '0 || m_rlast[j] !== 1'b0)) bad = 1'b1;
            end
            if (bad) begin
                miscompares++;
                $display("[TB] FAIL beat to m%0d: rvalid=%b rready=%b data=%h last=%b, want rvalid=%b rready=1 data=%h last=%b",
                         e.mst, m_rvalid, rready, m_rdata[e.mst], m_rlast[e.mst], 3'b001 << e.mst, e.data, e.last);
            end
            @(posedge clk); #1;
            if (e.last) outstanding--;
        end
        rvalid = 1'b0;
        rlast  = 1'b0;
    endtask

    task automatic test_reset();
        rst    = 1'b1;
        rvalid = 1'b1;
        rdata  = DW'(32'h1234);
        @(posedge clk); #1;
        @(negedge clk);
        vectors++;
        if (rready !== 1'b0 || m_rvalid !== 3'b000 || m_rdata !== '0 || r_err !== 1'b0 || arready_o !== 1'b1) begin
            miscompares++;
            $display("[TB] FAIL reset_state: rready=%b rvalid=%b r_err=%b arready_o=%b, want 0 000 0 1",
                     rready, m_rvalid, r_err, arready_o);
        end
        @(posedge clk); #1;
        rst    = 1'b0;
        rvalid = 1'b0;
        outstanding = 0;
        exp_q.delete();
    endtask

    task automatic test_empty_idle();
        rvalid = 1'b1;
        rlast  = 1'b1;
        rdata  = DW'(32'hEE);
        @(negedge clk);
        vectors++;
        if (rready !== 1'b0 || m_rvalid !== 3'b000) begin
            miscompares++;
            $display("[TB] FAIL empty_no_accept: rready=%b rvalid=%b, want 0 000", rready, m_rvalid);
        end
        @(posedge clk); #1;
        rvalid = 1'b0;
        rlast  = 1'b0;
    endtask

    task automatic test_single_m1();
        issue_ar(1, 3, 8'hA0);
        drain_scoreboard(4);
        test_empty_idle();
    endtask

    task automatic test_back_to_back();
        issue_ar(0, 0, 8'h10);
        issue_ar(2, 1, 8'h20);
        issue_ar(1, 0, 8'h30);
        drain_scoreboard(4);
        test_empty_idle();
    endtask

    task automatic test_full();
        beat_t e;
        issue_ar(0, 0, 8'h40);
        issue_ar(1, 0, 8'h41);
        issue_ar(2, 0, 8'h42);
        issue_ar(0, 0, 8'h43);
        // Held AR for m1 while full: must stall.
        grant = 3'b010; arvalid = 1'b1; arlen = '0;
        @(negedge clk);
        vectors++;
        if (arready_o !== 1'b0) begin
            miscompares++;
            $display("[TB] FAIL full_stall: arready_o=%b, want 0", arready_o);
        end
        @(posedge clk); #1;
        // Pop while still full: AR remains stalled this cycle.
        e = exp_q.pop_front();
        rvalid = 1'b1; rdata = e.data; rid = e.id; rresp = e.resp; rlast = e.last;
        @(negedge clk);
        vectors++;
        if (arready_o !== 1'b0 || rready !== 1'b1 || m_rvalid !== 3'b001 || m_rdata[0] !== e.data) begin
            miscompares++;
            $display("[TB] FAIL full_pop: arready_o=%b rready=%b rvalid=%b data=%h, want 0 1 001 %h",
                     arready_o, rready, m_rvalid, m_rdata[0], e.data);
        end
        @(posedge clk); #1;
        outstanding--;
        // Recovered: push and pop together keep the occupancy at 3.
        e = exp_q.pop_front();
        rdata = e.data; rid = e.id; rresp = e.resp; rlast = e.last;
        @(negedge clk);
        vectors++;
        if (arready_o !== 1'b1 || m_rvalid !== 3'b010 || m_rdata[1] !== e.data) begin
            miscompares++;
            $display("[TB] FAIL push_pop: arready_o=%b rvalid=%b data=%h, want 1 010 %h",
                     arready_o, m_rvalid, m_rdata[1], e.data);
        end
        @(posedge clk); #1;
        outstanding--;
        sb_push_burst(1, 0, 8'h44);
        rvalid = 1'b0; rlast = 1'b0;
        grant = 3'b100;
        @(negedge clk);
        vectors++;
        if (arready_o !== 1'b1) begin
            miscompares++;
            $display("[TB] FAIL count_kept: arready_o=%b, want 1", arready_o);
        end
        @(posedge clk); #1;
        sb_push_burst(2, 0, 8'h45);
        @(negedge clk);
        vectors++;
        if (arready_o !== 1'b0) begin
            miscompares++;
            $display("[TB] FAIL refull: arready_o=%b, want 0", arready_o);
        end
        @(posedge clk); #1;
        arvalid = 1'b0; grant = '0;
        drain_scoreboard(4);
    endtask

    task automatic test_backpressure();
        beat_t e;
        issue_ar(2, 1, 8'h50);
        e = exp_q.pop_front();
        rvalid = 1'b1; rdata = e.data; rid = e.id; rresp = e.resp; rlast = e.last;
        m_rready = 3'b011;
        for (int c = 0; c < 3; c++) begin
            @(negedge clk);
            vectors++;
            if (rready !== 1'b0 || m_rvalid !== 3'b100 || m_rdata[2] !== e.data) begin
                miscompares++;
                $display("[TB] FAIL stall_cycle%0d: rready=%b rvalid=%b data=%h, want 0 100 %h",
                         c, rready, m_rvalid, m_rdata[2], e.data);
            end
            @(posedge clk); #1;
        end
        m_rready = 3'b111;
        @(negedge clk);
        vectors++;
        if (rready !== 1'b1 || m_rdata[2] !== e.data) begin
            miscompares++;
            $display("[TB] FAIL stall_release: rready=%b data=%h, want 1 %h", rready, m_rdata[2], e.data);
        end
        @(posedge clk); #1;
        drain_scoreboard(1);
    endtask

    task automatic test_len_check();
        beat_t e;
        issue_ar(1, 3, 8'h60);
        for (int i = 0; i < 3; i++) begin
            e = exp_q.pop_front();
            rvalid = 1'b1; rdata = e.data; rid = e.id; rresp = e.resp; rlast = (i == 2);
            @(negedge clk);
            vectors++;
            if (m_rvalid !== 3'b010 || rready !== 1'b1 || r_err !== 1'b0) begin
                miscompares++;
                $display("[TB] FAIL len_beat%0d: rvalid=%b rready=%b r_err=%b, want 010 1 0",
                         i, m_rvalid, rready, r_err);
            end
            @(posedge clk); #1;
        end
        exp_q.delete();
        outstanding = 0;
        rlast = 1'b0;
        for (int c = 0; c < 3; c++) begin
            @(negedge clk);
            vectors++;
            if (r_err !== LEN_CHECK || rready !== 1'b0) begin
                miscompares++;
                $display("[TB] FAIL len_err%0d: r_err=%b rready=%b, want %b 0", c, r_err, rready, LEN_CHECK);
            end
            @(posedge clk); #1;
        end
        rvalid = 1'b0;
    endtask

    task automatic test_reset_mid();
        beat_t e;
        issue_ar(1, 3, 8'h70);
        drain_scoreboard(2);
        e = exp_q.pop_front();
        rvalid = 1'b1; rdata = e.data; rid = e.id; rresp = e.resp; rlast = 1'b0;
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        exp_q.delete();
        outstanding = 0;
        @(negedge clk);
        vectors++;
        if (rready !== 1'b0 || m_rvalid !== 3'b000 || m_rdata !== '0 || r_err !== 1'b0 || arready_o !== 1'b1) begin
            miscompares++;
            $display("[TB] FAIL reset_mid: rready=%b rvalid=%b r_err=%b arready_o=%b, want 0 000 0 1",
                     rready, m_rvalid, r_err, arready_o);
        end
        @(posedge clk); #1;
        rvalid = 1'b0;
        issue_ar(0, 1, 8'h80);
        drain_scoreboard(2);
    endtask

    initial begin
        test_reset();
        test_single_m1();
        test_back_to_back();
        test_full();
        test_backpressure();
        test_len_check();
        test_reset_mid();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

    initial begin
        #200000;
        $display("[TB] FAIL timeout: simulation still running at %0t, want finished", $time);
        $fatal(1, "[TB] timeout");
    end

endmodule
